// File: rtl/seq_shift_add_multiplier.sv
// Iterative radix-2 shift-and-add multiplier with a 2*WIDTH-bit product and valid/ready handshakes.
// Signed operands are reduced to magnitudes up front and the sign is restored in one final step.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e               state_q,     state_d;
  logic [WIDTH-1:0]     mcand_q,     mcand_d;
  logic [WIDTH-1:0]     high_q,      high_d;
  logic [WIDTH-1:0]     low_q,       low_d;
  logic                 signed_q,    signed_d;
  logic                 neg_q,       neg_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [2*WIDTH-1:0]   product_q,   product_d;
  logic                 out_valid_q, out_valid_d;

  // Adder port: one WIDTH-bit add per RUN cycle, carry-in tied low.
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic [WIDTH-1:0]     run_sum;
  logic                 run_cout;

  assign {add_cout, add_sum} = {1'b0, high_q} + {1'b0, mcand_q} + {{WIDTH{1'b0}}, 1'b0};

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

  // Next-state and datapath update for the whole transaction sequence.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    high_d      = high_q;
    low_d       = low_q;
    signed_d    = signed_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    run_sum     = high_q;
    run_cout    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = a;
          low_d    = b;
          signed_d = is_signed;
          state_d  = S_PREP;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_PREP: begin
        // The most negative value negates to itself, which reads as 2^(WIDTH-1) unsigned.
        neg_d = signed_q & (mcand_q[WIDTH-1] ^ low_q[WIDTH-1]);
        if (signed_q && mcand_q[WIDTH-1]) begin
          mcand_d = ~mcand_q + WIDTH'(1);
        end else begin
          mcand_d = mcand_q;
        end
        if (signed_q && low_q[WIDTH-1]) begin
          low_d = ~low_q + WIDTH'(1);
        end else begin
          low_d = low_q;
        end
        high_d  = {WIDTH{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_RUN;
      end

      S_RUN: begin
        if (low_q[0]) begin
          run_sum  = add_sum;
          run_cout = add_cout;
        end else begin
          run_sum  = high_q;
          run_cout = 1'b0;
        end
        high_d = {run_cout, run_sum[WIDTH-1:1]};
        low_d  = {run_sum[0], low_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end

      S_FIX: begin
        if (neg_q) begin
          product_d = ~{high_q, low_q} + (2*WIDTH)'(1);
        end else begin
          product_d = {high_q, low_q};
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= {WIDTH{1'b0}};
      high_q      <= {WIDTH{1'b0}};
      low_q       <= {WIDTH{1'b0}};
      signed_q    <= 1'b0;
      neg_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      product_q   <= {(2*WIDTH){1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      high_q      <= high_d;
      low_q       <= low_d;
      signed_q    <= signed_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
